// File: rtl/turn_signal_scheduler.sv
// turn_signal_scheduler: conditions the raw switch requests, arbitrates
// left/right/hazard and generates the blink-step tick for the taillight FSM.
module turn_signal_scheduler #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int TURN_LEN   = 4,
  parameter int HAZ_LEN    = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       L_in,
  input  logic       R_in,
  input  logic       H_in,
  output logic       Enable,
  output logic       L,
  output logic       R,
  output logic       H,
  output logic [1:0] Mode,
  output logic [1:0] Phase
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [1:0]        TURN_LAST = 2'(TURN_LEN - 1);
  localparam logic [1:0]        HAZ_LAST  = 2'(HAZ_LEN - 1);

  // Bit order for the per-input vectors: [2]=hazard, [1]=right, [0]=left
  logic [2:0]       raw_req;
  logic [2:0]       sync_1;
  logic [2:0]       sync_2;
  logic [2:0]       filt_req;
  logic [DEB_W-1:0] deb_cnt [3];

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  mode_t      request;
  mode_t      mode_q;
  mode_t      mode_d;
  logic [1:0] phase_q;
  logic [1:0] phase_d;

  assign raw_req = {H_in, R_in, L_in};

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_req;
      sync_2 <= sync_1;
    end
  end

  // Debounce: accept a change only after it has been stable DEB_CYCLES cycles
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_req <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == filt_req[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt_req[i] <= sync_2[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Free-running blink divider; tick is registered so it lands one cycle after the wrap count
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (tick_cnt == TICK_LAST);
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Enable trails tick by one cycle so the commands are already settled when it pulses
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Enable <= 1'b0;
    end else begin
      Enable <= tick;
    end
  end

  // Priority decode of the filtered requests; both turns together mean hazard
  always_comb begin
    request = MODE_IDLE;
    if (filt_req[2] || (filt_req[0] && filt_req[1])) begin
      request = MODE_HAZARD;
    end else if (filt_req[0]) begin
      request = MODE_LEFT;
    end else if (filt_req[1]) begin
      request = MODE_RIGHT;
    end
  end

  // Mode/phase next state: only a tick advances; turns finish unless hazard preempts
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (tick) begin
      case (mode_q)
        MODE_IDLE: begin
          if (request != MODE_IDLE) begin
            mode_d  = request;
            phase_d = 2'd0;
          end
        end
        MODE_LEFT, MODE_RIGHT: begin
          if (request == MODE_HAZARD) begin
            mode_d  = MODE_HAZARD;
            phase_d = 2'd0;
          end else if (phase_q < TURN_LAST) begin
            phase_d = phase_q + 2'd1;
          end else begin
            mode_d  = request;
            phase_d = 2'd0;
          end
        end
        MODE_HAZARD: begin
          if (phase_q < HAZ_LAST) begin
            phase_d = phase_q + 2'd1;
          end else begin
            mode_d  = request;
            phase_d = 2'd0;
          end
        end
        default: begin
          mode_d  = MODE_IDLE;
          phase_d = 2'd0;
        end
      endcase
    end
  end

  // Mode/phase register plus the one-hot command flops, which always mirror the mode
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q  <= MODE_IDLE;
      phase_q <= 2'd0;
      L       <= 1'b0;
      R       <= 1'b0;
      H       <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      L       <= (mode_d == MODE_LEFT);
      R       <= (mode_d == MODE_RIGHT);
      H       <= (mode_d == MODE_HAZARD);
    end
  end

  assign Mode  = mode_q;
  assign Phase = phase_q;

endmodule
